// File: rtl/codel_control_law_seq.sv
// CoDel control law: next_drop = time + interval / sqrt(count), computed over several
// cycles with a Newton-Raphson inverse square root and a one-entry cache of the last r.
module codel_control_law_seq #(
  parameter int unsigned TIME_W       = 32,
  parameter int unsigned COUNT_W      = 16,
  parameter int unsigned FRAC_W       = 16,
  parameter int unsigned NEWTON_ITERS = 4
) (
  input  logic               i__clk,
  input  logic               i__reset,
  input  logic               i__valid,
  output logic               o__ready,
  input  logic [TIME_W-1:0]  i__time,
  input  logic [TIME_W-1:0]  i__interval,
  input  logic [COUNT_W-1:0] i__count,
  input  logic               i__flush,
  output logic               o__valid,
  input  logic               i__out_ready,
  output logic [TIME_W-1:0]  o__output
);

  localparam int unsigned R_W   = FRAC_W + 1;
  localparam int unsigned R2_W  = 2 * R_W;
  localparam int unsigned T_W   = COUNT_W + R_W;
  localparam int unsigned K_W   = FRAC_W + 2;
  localparam int unsigned P_W   = R_W + K_W;
  localparam int unsigned S_W   = TIME_W + R_W;
  localparam int unsigned MSB_W = $clog2(COUNT_W) + 1;
  localparam int unsigned IT_W  = $clog2(NEWTON_ITERS) + 1;

  localparam logic [R_W-1:0] ONE_R   = {1'b1, {FRAC_W{1'b0}}};
  localparam logic [T_W-1:0] THREE_T = T_W'(3) << FRAC_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEED  = 3'd1,
    S_ITER  = 3'd2,
    S_SCALE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_nx;
  logic [TIME_W-1:0]    r_time;
  logic [TIME_W-1:0]    r_interval;
  logic [COUNT_W-1:0]   r_count;
  logic [R_W-1:0]       r_r;
  logic [IT_W-1:0]      r_iter;
  logic                 r_ready;
  logic                 r_valid;
  logic [TIME_W-1:0]    r_output;
  logic                 r_c_valid;
  logic [COUNT_W-1:0]   r_c_count;
  logic [R_W-1:0]       r_c_r;

  logic                 w_accept;
  logic                 w_hit;
  logic [COUNT_W-1:0]   w_cnt_in;
  logic                 w_ld_seed;
  logic                 w_step;
  logic                 w_scale;
  logic [MSB_W-1:0]     w_msb;
  logic [R_W-1:0]       w_r0;
  logic [R_W-1:0]       w_y;
  logic [T_W-1:0]       w_t;
  logic [K_W-1:0]       w_k;
  logic [P_W-1:0]       w_rn;
  logic [R_W-1:0]       w_r_next;
  logic [TIME_W-1:0]    w_out;

  assign o__ready = r_ready;
  assign o__valid = r_valid;
  assign o__output = r_output;

  assign w_accept = (r_state == S_IDLE) & i__valid;
  assign w_cnt_in = (i__count == '0) ? COUNT_W'(1) : i__count;
  // A flush in the accept cycle must not be beaten by the stale cache entry.
  assign w_hit = r_c_valid & ~i__flush & (w_cnt_in == r_c_count);

  // Seed: r0 = 1.0 >> ceil-ish half of the count's MSB index.
  always_comb begin
    w_msb = '0;
    for (int i = 0; i < COUNT_W; i++) begin
      if (r_count[i]) w_msb = MSB_W'(i);
    end
    w_r0 = ONE_R >> ((MSB_W'(1) + w_msb) >> 1);
  end

  // One Newton step on r, truncating and saturated to 1.0.
  always_comb begin
    w_y = R_W'((R2_W'(r_r) * R2_W'(r_r)) >> FRAC_W);
    w_t = T_W'(r_count) * T_W'(w_y);
    w_k = (w_t >= THREE_T) ? '0 : K_W'(THREE_T - w_t);
    w_rn = (P_W'(r_r) * P_W'(w_k)) >> (FRAC_W + 1);
    w_r_next = (w_rn > P_W'(ONE_R)) ? ONE_R : R_W'(w_rn);
  end

  assign w_out = r_time + TIME_W'((S_W'(r_interval) * S_W'(r_r)) >> FRAC_W);

  always_ff @(posedge i__clk or posedge i__reset) begin
    if (i__reset) r_state <= S_IDLE;
    else          r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nx = w_hit ? S_SCALE : S_SEED;
      S_SEED:  w_state_nx = S_ITER;
      S_ITER:  if (r_iter == IT_W'(NEWTON_ITERS - 1)) w_state_nx = S_SCALE;
      S_SCALE: w_state_nx = S_DONE;
      S_DONE:  if (i__out_ready) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    w_ld_seed = 1'b0;
    w_step    = 1'b0;
    w_scale   = 1'b0;
    case (r_state)
      S_SEED:  w_ld_seed = 1'b1;
      S_ITER:  w_step    = 1'b1;
      S_SCALE: w_scale   = 1'b1;
      default: ;
    endcase
  end

  // Datapath and registered handshake outputs.
  always_ff @(posedge i__clk or posedge i__reset) begin
    if (i__reset) begin
      r_time     <= '0;
      r_interval <= '0;
      r_count    <= '0;
      r_r        <= '0;
      r_iter     <= '0;
      r_ready    <= 1'b1;
      r_valid    <= 1'b0;
      r_output   <= '0;
    end else begin
      r_ready <= (w_state_nx == S_IDLE);
      r_valid <= (w_state_nx == S_DONE);
      if (w_accept) begin
        r_time     <= i__time;
        r_interval <= i__interval;
        r_count    <= w_cnt_in;
        if (w_hit) r_r <= r_c_r;
      end
      if (w_ld_seed) begin
        r_r    <= w_r0;
        r_iter <= '0;
      end
      if (w_step) begin
        r_r    <= w_r_next;
        r_iter <= r_iter + IT_W'(1);
      end
      if (w_scale) r_output <= w_out;
    end
  end

  // Cache; a flush on the same edge as the write leaves it invalid.
  always_ff @(posedge i__clk or posedge i__reset) begin
    if (i__reset) begin
      r_c_valid <= 1'b0;
      r_c_count <= '0;
      r_c_r     <= '0;
    end else begin
      if (w_scale) begin
        r_c_count <= r_count;
        r_c_r     <= r_r;
      end
      if (i__flush)     r_c_valid <= 1'b0;
      else if (w_scale) r_c_valid <= 1'b1;
    end
  end

endmodule
